// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter. Log-shifter levels are distributed across STAGES
// registered stages behind a valid/ready elastic handshake with flush.
module shift_unit_pipe #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int STAGES  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [XLEN-1:0]    i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_op,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_data
);

  localparam int K = (SHAMT_W + STAGES - 1) / STAGES;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [XLEN-1:0]    data_p   [STAGES];
  logic [SHAMT_W-1:0] shamt_p  [STAGES];
  logic [1:0]         op_p     [STAGES];
  logic [STAGES-1:0]  vld_p;
  logic [STAGES-1:0]  adv;

  logic [XLEN-1:0]    data_in  [STAGES];
  logic [SHAMT_W-1:0] shamt_in [STAGES];
  logic [1:0]         op_in    [STAGES];
  logic [STAGES-1:0]  vld_in;
  logic [XLEN-1:0]    data_nxt [STAGES];

  // Applies the levels lo..hi-1 selected by sh. SRA stays correct across stages because the
  // running value's MSB is still the original sign bit after every partial arithmetic shift.
  function automatic logic [XLEN-1:0] shift_levels(input logic [XLEN-1:0]    d,
                                                   input logic [SHAMT_W-1:0] sh,
                                                   input logic [1:0]         op,
                                                   input int                 lo,
                                                   input int                 hi);
    logic [XLEN-1:0]        r;
    logic signed [XLEN-1:0] rs;
    int                     amt;
    r = d;
    for (int l = 0; l < SHAMT_W; l++) begin
      if (l >= lo && l < hi && sh[l]) begin
        amt = 1 << l;
        case (op)
          OP_SLL:  r = r << amt;
          OP_SRL:  r = r >> amt;
          OP_SRA: begin
            rs = r;
            r  = rs >>> amt;
          end
          default: r = (r >> amt) | (r << (XLEN - amt));
        endcase
      end
    end
    return r;
  endfunction

  always_comb begin
    vld_in   = '0;
    adv      = '0;
    data_in  = '{default: '0};
    shamt_in = '{default: '0};
    op_in    = '{default: '0};
    data_nxt = '{default: '0};
    vld_in[0]   = i_valid;
    data_in[0]  = i_data;
    shamt_in[0] = i_shamt;
    op_in[0]    = i_op;
    for (int s = 1; s < STAGES; s++) begin
      vld_in[s]   = vld_p[s-1];
      data_in[s]  = data_p[s-1];
      shamt_in[s] = shamt_p[s-1];
      op_in[s]    = op_p[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      data_nxt[s] = shift_levels(data_in[s], shamt_in[s], op_in[s], s * K, (s + 1) * K);
    end
    // Advance ripples back from the output so a full pipe still moves at full rate
    adv[STAGES-1] = !vld_p[STAGES-1] | i_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      adv[s] = !vld_p[s] | adv[s+1];
    end
  end

  // Stage registers p0..p(STAGES-1); flush wins over advance for the valid bits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_p[s]  <= '0;
        shamt_p[s] <= '0;
        op_p[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (i_flush) begin
          vld_p[s] <= 1'b0;
        end else if (adv[s]) begin
          vld_p[s] <= vld_in[s];
        end
        if (adv[s] && vld_in[s]) begin
          data_p[s]  <= data_nxt[s];
          shamt_p[s] <= shamt_in[s];
          op_p[s]    <= op_in[s];
        end
      end
    end
  end

  assign o_ready = adv[0];
  assign o_valid = vld_p[STAGES-1];
  assign o_data  = data_p[STAGES-1];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed latency/boundary scenarios plus randomized streams
// checked against a queue-based reference model, for several XLEN/STAGES configurations.
module tb_shift_unit_pipe;

  localparam int STG = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;

  logic        aux_flush;
  logic        a8_valid, a8_iready, a8_ovalid, a8_rdy;
  logic [7:0]  a8_data, a8_dout;
  logic [2:0]  a8_shamt;
  logic [1:0]  a8_op;
  logic        a64_valid, a64_iready, a64_ovalid, a64_rdy;
  logic [63:0] a64_data, a64_dout;
  logic [5:0]  a64_shamt;
  logic [1:0]  a64_op;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  shift_unit_pipe #(.XLEN(32), .STAGES(STG)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(in_ready),
    .i_data(in_data), .i_shamt(in_shamt), .i_op(in_op), .o_valid(out_valid),
    .i_ready(out_ready), .o_data(out_data));

  shift_unit_pipe #(.XLEN(8), .STAGES(1)) u8 (
    .i_clk(clk), .i_rst(rst), .i_flush(aux_flush), .i_valid(a8_valid), .o_ready(a8_iready),
    .i_data(a8_data), .i_shamt(a8_shamt), .i_op(a8_op), .o_valid(a8_ovalid),
    .i_ready(a8_rdy), .o_data(a8_dout));

  shift_unit_pipe #(.XLEN(64), .STAGES(5)) u64 (
    .i_clk(clk), .i_rst(rst), .i_flush(aux_flush), .i_valid(a64_valid), .o_ready(a64_iready),
    .i_data(a64_data), .i_shamt(a64_shamt), .i_op(a64_op), .o_valid(a64_ovalid),
    .i_ready(a64_rdy), .o_data(a64_dout));

  // Reference: the architectural result of op on an xl-bit operand, by plain arithmetic.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh,
                                            input logic [1:0] op, input int xl);
    logic [63:0]         mask, dm, r;
    logic signed [127:0] sx;
    mask = (xl == 64) ? '1 : ((64'd1 << xl) - 64'd1);
    dm   = d & mask;
    case (op)
      2'b00: r = (dm << sh) & mask;
      2'b01: r = dm >> sh;
      2'b10: begin
        sx = $signed({64'd0, dm} << (128 - xl));
        sx = sx >>> (128 - xl);
        sx = sx >>> sh;
        r  = sx[63:0] & mask;
      end
      default: r = ((dm >> sh) | (dm << (xl - sh))) & mask;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_o_valid: got %b want 0", out_valid); else passes++;
    checks++; if (out_data !== 32'h0) $display("FAIL reset_o_data: got %h want 0", out_data); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_o_ready: got %b want 1", in_ready); else passes++;
    checks++; if (a64_ovalid !== 1'b0 || a64_dout !== 64'h0)
      $display("FAIL reset_x64: got %b/%h want 0/0", a64_ovalid, a64_dout); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [31:0] din [4] = '{32'h0000_0001, 32'h8000_00F0, 32'h8000_00F0, 32'h0000_0001};
    logic [4:0]  sh  [4] = '{5'd31, 5'd4, 5'd4, 5'd1};
    logic [31:0] exp [4] = '{32'h8000_0000, 32'hF800_000F, 32'h0800_000F, 32'h8000_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = din[i]; in_shamt = sh[i]; in_op = ops[i];
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL dir_ready[%0d]: got %b want 1", i, in_ready); else passes++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL dir_early[%0d]: got %b want 0", i, out_valid); else passes++;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i])
        $display("FAIL dir_result[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, exp[i]); else passes++;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL dir_once[%0d]: got %b want 0", i, out_valid); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [8];
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      in_valid = (k < 8);
      in_data  = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
      if (k < 8) exp[k] = 32'(ref_shift(64'(in_data), int'(in_shamt), in_op, 32));
      #1;
      if (k < 8) begin
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready); else passes++;
      end
      checks++; if (out_valid !== (k >= 2 && k <= 9))
        $display("FAIL b2b_valid[%0d]: got %b want %b", k, out_valid, (k >= 2 && k <= 9)); else passes++;
      if (k >= 2 && k <= 9) begin
        checks++; if (out_data !== exp[k-2])
          $display("FAIL b2b_data[%0d]: got %h want %h", k, out_data, exp[k-2]); else passes++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // mode 0: shamt=0 identity at full rate; 1: 5-cycle downstream stall; 2: random valid/ready
  task automatic test_stream(input int n, input int mode);
    logic [31:0] q[$];
    logic [31:0] held, exp;
    logic        was_stall = 1'b0;
    logic        saw_full = 1'b0;
    int          sent = 0;
    int          cyc = 0;
    while ((sent < n || q.size() > 0) && cyc < n * 4 + 50) begin
      in_valid  = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_op     = 2'($urandom);
      in_shamt  = (mode == 0) ? 5'd0 : 5'($urandom);
      out_ready = (mode == 1) ? !(cyc >= 4 && cyc < 9) : (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      checks++; if (in_ready !== !(q.size() == STG && !out_ready))
        $display("FAIL stream_ready m%0d c%0d: got %b want %b", mode, cyc, in_ready, !(q.size() == STG && !out_ready));
      else passes++;
      if (!in_ready) saw_full = 1'b1;
      if (was_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== held)
          $display("FAIL stream_hold m%0d c%0d: got %b/%h want 1/%h", mode, cyc, out_valid, out_data, held);
        else passes++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL stream_spurious m%0d c%0d: got %h want none", mode, cyc, out_data);
        else begin
          exp = q.pop_front();
          if (out_data !== exp) $display("FAIL stream_data m%0d c%0d: got %h want %h", mode, cyc, out_data, exp);
          else passes++;
        end
      end
      was_stall = out_valid && !out_ready;
      held      = out_data;
      if (in_valid && in_ready) begin
        q.push_back(32'(ref_shift(64'(in_data), int'(in_shamt), in_op, 32)));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (sent != n || q.size() != 0)
      $display("FAIL stream_drain m%0d: got sent %0d left %0d want %0d/0", mode, sent, q.size(), n); else passes++;
    if (mode == 1) begin
      checks++; if (saw_full !== 1'b1) $display("FAIL stream_full: got o_ready never low want low"); else passes++;
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_op = 2'b00; in_shamt = 5'd0;
    in_valid = 1'b1; in_data = 32'hAAAA_0001;
    @(posedge clk); #1;
    in_data = 32'hBBBB_0002;
    @(posedge clk); #1;
    in_data = 32'hCCCC_0003; flush = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL flush_pre: got v%b r%b want v1 r0", out_valid, in_ready); else passes++;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_clear: got %b want 0", out_valid); else passes++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_none[%0d]: got %b want 0", i, out_valid); else passes++;
    end
    in_valid = 1'b1; in_data = 32'hDDDD_0004;
    @(posedge clk); #1;
    in_data = 32'hEEEE_0005; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_offer_ready: got %b want 1", in_ready); else passes++;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_discard[%0d]: got %b want 0", i, out_valid); else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d0;
    d0 = $urandom | 32'h1;
    out_ready = 1'b0; in_valid = 1'b1; in_shamt = 5'd0; in_op = 2'($urandom); in_data = d0;
    @(posedge clk); #1;
    in_data = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== d0)
      $display("FAIL rstmid_pre: got %b/%h want 1/%h", out_valid, out_data, d0); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL rstmid_async: got %b/%h want 0/0", out_valid, out_data); else passes++;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid_lost: got v%b r%b want v0 r1", out_valid, in_ready); else passes++;
  endtask

  task automatic test_configs(input int n);
    logic [63:0] q8[$], q64[$];
    logic [63:0] exp;
    int s8 = 0, s64 = 0, cyc = 0;
    while ((s8 < n || s64 < n || q8.size() > 0 || q64.size() > 0) && cyc < n * 6 + 50) begin
      a8_valid  = (s8 < n) && ($urandom_range(0, 3) != 0);
      a8_data   = 8'($urandom); a8_shamt = 3'($urandom); a8_op = 2'($urandom);
      a8_rdy    = ($urandom_range(0, 3) != 0);
      a64_valid = (s64 < n) && ($urandom_range(0, 3) != 0);
      a64_data  = {$urandom, $urandom}; a64_shamt = 6'($urandom); a64_op = 2'($urandom);
      a64_rdy   = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (a8_iready !== !(q8.size() == 1 && !a8_rdy))
        $display("FAIL x8_ready c%0d: got %b want %b", cyc, a8_iready, !(q8.size() == 1 && !a8_rdy)); else passes++;
      checks++; if (a64_iready !== !(q64.size() == 5 && !a64_rdy))
        $display("FAIL x64_ready c%0d: got %b want %b", cyc, a64_iready, !(q64.size() == 5 && !a64_rdy)); else passes++;
      if (a8_ovalid && a8_rdy) begin
        checks++;
        if (q8.size() == 0) $display("FAIL x8_spurious c%0d: got %h want none", cyc, a8_dout);
        else begin
          exp = q8.pop_front();
          if (a8_dout !== exp[7:0]) $display("FAIL x8_data c%0d: got %h want %h", cyc, a8_dout, exp[7:0]);
          else passes++;
        end
      end
      if (a64_ovalid && a64_rdy) begin
        checks++;
        if (q64.size() == 0) $display("FAIL x64_spurious c%0d: got %h want none", cyc, a64_dout);
        else begin
          exp = q64.pop_front();
          if (a64_dout !== exp) $display("FAIL x64_data c%0d: got %h want %h", cyc, a64_dout, exp);
          else passes++;
        end
      end
      if (a8_valid && a8_iready) begin
        q8.push_back(ref_shift(64'(a8_data), int'(a8_shamt), a8_op, 8)); s8++;
      end
      if (a64_valid && a64_iready) begin
        q64.push_back(ref_shift(a64_data, int'(a64_shamt), a64_op, 64)); s64++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a8_valid = 1'b0; a64_valid = 1'b0;
    checks++; if (s8 != n || s64 != n || q8.size() != 0 || q64.size() != 0)
      $display("FAIL cfg_drain: got %0d/%0d left %0d/%0d want %0d", s8, s64, q8.size(), q64.size(), n);
    else passes++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_op = '0;
    aux_flush = 1'b0;
    a8_valid = 1'b0; a8_rdy = 1'b1; a8_data = '0; a8_shamt = '0; a8_op = '0;
    a64_valid = 1'b0; a64_rdy = 1'b1; a64_data = '0; a64_shamt = '0; a64_op = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stream(40, 0);
    test_stream(30, 1);
    test_flush();
    test_stream(300, 2);
    test_reset_midstream();
    test_configs(150);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
